mac_sequencer: RTL

Controller for the fixed-point multiply-accumulate datapath. It sequences one dot-product pass: it issues operand read addresses, tracks products through the multiplier's register pipeline, and accumulates them into a signed ACC_W result. It sits between the top-level classifier control (start/done) and the operand memories and multiplier, and owns the accumulator register.

---
 rtl/mac_seq_pkg.sv | 22 ++
 rtl/mac_sequencer_vld_delay.sv | 36 +++
 rtl/mac_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and saturation-limit helpers for the MAC sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int ACC_W_DEF = 26;

    // Limits for a w-bit signed accumulator; callers truncate to w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/mac_sequencer_vld_delay.sv
// vld_delay: DEPTH-deep 1-bit valid shift register with async active-low reset.
// empty_o means no valid sits behind the output stage, so the line is empty after the next edge.
module vld_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o,
    output logic empty_o
);

    logic [DEPTH-1:0] sh_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q <= '0;
        end else begin
            sh_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) begin
                sh_q[i] <= sh_q[i-1];
            end
        end
    end

    assign out_o = sh_q[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_empty_single
            assign empty_o = 1'b1;
        end else begin : g_empty_multi
            assign empty_o = ~|sh_q[DEPTH-2:0];
        end
    endgenerate

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product pass sequencer: issues operand reads, tracks products, accumulates the result.
// Define MAC_SEQ_SAT_EN to saturate the accumulator and report sticky overflow; otherwise it wraps.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int PROD_W   = 19,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  result,
    output logic              done,
    output logic              ovf
);

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;
    logic              vld_out;
    logic              vld_empty;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum;

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_addr = ADDR_W'(len_q) - ADDR_W'(1);

    vld_delay #(
        .DEPTH(PIPE_LAT)
    ) u_vld_delay (
        .clk    (clk),
        .rst    (rst),
        .in_i   (rd_en_q),
        .out_o  (vld_out),
        .empty_o(vld_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        rd_addr_q <= '0;
                        if (len != '0) begin
                            len_q   <= len;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (rd_addr_q == last_addr) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The last product is being added on this edge, so done lines up with a final result.
                    if (vld_empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = acc_q + prod_ext;

`ifdef MAC_SEQ_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    logic ovf_q;
    logic ovf_d;
    logic add_ovf;

    assign add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (vld_out) begin
            if (add_ovf) begin
                acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (vld_out) begin
            acc_d = sum;
        end
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign busy    = busy_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign done    = done_q;
    assign result  = acc_q;

endmodule
